// File: rtl/serial_match_controller_if.sv
// Host-side bundle for serial_match_controller: config handshake, run control,
// serial input and match/status outputs.
interface serial_match_controller_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_threshold;
  logic             start;
  logic             stop;
  logic             serial_line;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  // Host / sequencer side
  modport master (
    output cfg_valid, cfg_pattern, cfg_threshold, start, stop, serial_line,
    input  cfg_ready, match, match_count, busy, done
  );

  // Controller side
  modport slave (
    input  cfg_valid, cfg_pattern, cfg_threshold, start, stop, serial_line,
    output cfg_ready, match, match_count, busy, done
  );
endinterface

// File: rtl/serial_match_controller.sv
// Programmable serial-pattern detector: shifts serial_line into a PAT_W history,
// pulses match on every (overlapping) hit, counts hits and stops in DONE when the
// configured threshold is reached.
module serial_match_controller #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                      clock,
  input logic                      reset,
  serial_match_controller_if.slave bus
);

  localparam int unsigned FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FillLast = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StHunt, StDone} state_e;

  state_e            r_state;
  logic [PAT_W-1:0]  r_pattern;
  logic [CNT_W-1:0]  r_threshold;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_match;
  logic [CNT_W-1:0]  r_count;

  logic [PAT_W-1:0]  w_next_hist;
  logic              w_hit;
  logic [CNT_W:0]    w_count_inc;
  logic [CNT_W-1:0]  w_count_sat;
  logic              w_thr_reached;
  logic              w_cfg_fire;

  // History shift, hit detect and saturating count arithmetic
  always_comb begin
    w_next_hist   = {r_hist[PAT_W-2:0], bus.serial_line};
    w_hit         = (w_next_hist == r_pattern);
    w_count_inc   = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
    w_count_sat   = (&r_count) ? r_count : w_count_inc[CNT_W-1:0];
    // Widened compare so a saturated count never aliases onto the threshold
    w_thr_reached = (r_threshold != '0) && (w_count_inc == {1'b0, r_threshold});
    w_cfg_fire    = bus.cfg_valid && (r_state == StIdle);
  end

  // Control FSM with registered match pulse and hit counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_pattern   <= '0;
      r_threshold <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_match     <= 1'b0;
      r_count     <= '0;
    end else begin
      r_match <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_cfg_fire) begin
            r_pattern   <= bus.cfg_pattern;
            r_threshold <= bus.cfg_threshold;
          end
          if (bus.start && !bus.stop) begin
            r_state <= StArmed;
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
          end
        end
        StArmed: begin
          if (bus.stop) begin
            r_state <= StIdle;
          end else begin
            r_hist <= w_next_hist;
            r_fill <= r_fill + FILL_W'(1);
            // Hits only count once a full window has been sampled
            if (r_fill == FillLast) begin
              r_state <= StHunt;
              if (w_hit) begin
                r_match <= 1'b1;
                r_count <= w_count_sat;
                if (w_thr_reached) r_state <= StDone;
              end
            end
          end
        end
        StHunt: begin
          if (bus.stop) begin
            r_state <= StIdle;
          end else begin
            // History is kept across hits so overlapping patterns count
            r_hist <= w_next_hist;
            if (w_hit) begin
              r_match <= 1'b1;
              r_count <= w_count_sat;
              if (w_thr_reached) r_state <= StDone;
            end
          end
        end
        StDone: begin
          if (bus.stop) begin
            r_state <= StIdle;
          end else if (bus.start) begin
            r_state <= StArmed;
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Status outputs decoded from registered state only
  always_comb begin
    bus.cfg_ready   = (r_state == StIdle);
    bus.match       = r_match;
    bus.match_count = r_count;
    bus.busy        = (r_state == StArmed) || (r_state == StHunt);
    bus.done        = (r_state == StDone);
  end

endmodule

// File: doc/serial_match_controller.md
Name: serial_match_controller

Overview:
- Programmable serial-pattern detection controller that sequences the serial-line matcher datapath.
- Accepts a pattern and match threshold through a valid/ready config port and arms or disarms detection on start/stop commands.
- Samples serial_line once per clock, pulses match on every pattern hit, with overlapping hits allowed.
- Counts hits and raises done when the threshold is reached; sits between a host/sequencer and the serial input.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- CNT_W, 8, width of match counter and threshold.

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config can be accepted; high only in IDLE.
- cfg_pattern  input  PAT_W  pattern; MSB is the oldest bit.
- cfg_threshold  input  CNT_W  matches required for done; 0 means run until stop.
- start  input  1  arm detection (level sampled each cycle).
- stop  input  1  abort or disarm.
- serial_line  input  1  serial data, sampled each posedge while armed.
- match  output  1  one-cycle registered pulse per pattern hit.
- match_count  output  CNT_W  hits since last start; saturates at all-ones.
- busy  output  1  high in ARMED or HUNT.
- done  output  1  high while in DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - pattern=0, threshold=0.
  - hist=0, fill=0.
  - match=0, match_count=0, busy=0, done=0.
  - cfg_ready=1 once out of reset.
- Config handshake:
  - Transfer occurs when cfg_valid&&cfg_ready at a posedge; pattern and threshold register on that edge.
  - cfg_valid outside IDLE is ignored (no stall, no latch).
- History update:
  - next_hist = {hist[PAT_W-2:0], serial_line}.
  - hit = (next_hist == pattern).
- States:
  - IDLE: start=1 -> ARMED. Clear hist, fill and match_count on that edge. Config may transfer on the same edge as start; the new config is used.
  - ARMED (window filling):
    - Each cycle: hist<=next_hist, fill<=fill+1.
    - When fill==PAT_W-1, this sample completes the window: evaluate hit and go to HUNT.
    - No hit is possible before PAT_W samples.
  - HUNT:
    - Each cycle: hist<=next_hist and evaluate hit.
    - Overlapping matches count; the history is never cleared on a hit.
  - DONE:
    - done=1; the hold value of match_count is kept.
    - start -> ARMED with a full clear.
    - stop -> IDLE.
- Hit handling, on the edge that samples the completing bit:
  - match<=1 for exactly one cycle.
  - match_count<=match_count+1, saturating.
  - If threshold!=0 and match_count+1==threshold: state<=DONE on the same edge. match and done then rise together.
  - Latency is one cycle from the sampling edge to a visible match.
- Stop:
  - stop in ARMED or HUNT -> IDLE next edge. Any hit on that edge is suppressed (match=0, no count); match_count is retained.
  - start and stop in the same cycle: stop wins everywhere.
  - start in ARMED or HUNT (without stop) is ignored.
- Threshold:
  - Threshold 0: never enters DONE. The count saturates at 2^CNT_W-1 and match still pulses.
  - Threshold changes apply only via config in IDLE.
- busy and done are decoded from registered state; no combinational path from inputs to outputs.
- Reset asserted mid-operation: immediate return to reset values, independent of clock.

Test Plan:
- Reset/config:
  - Stimulus: hold reset=0 for 5 cycles, release, then cfg pattern=4'b1011, threshold=2.
  - Required: all outputs 0, cfg_ready=1, handshake accepted in one cycle.
- Overlap and done:
  - Stimulus: start, then serial 1,0,1,1,0,1,1.
  - Required: match pulses one cycle after the 4th and 7th samples, match_count=1 then 2, done=1 coincident with the second match, busy=0.
- Window fill:
  - Stimulus: pattern=4'b0000, serial all 0 from start.
  - Required: first match only after the 4th sample, then every cycle; match_count increments by 1 per cycle.
- Stop priority:
  - Stimulus: in HUNT, assert start+stop on the cycle that completes a hit.
  - Required: match=0, count unchanged, state IDLE, cfg_ready=1.
- Threshold 0 saturation:
  - Stimulus: CNT_W=3, threshold=0, pattern all-zero stream for 12 cycles.
  - Required: match_count stops at 7, done never asserts, match continues to pulse.
- Async reset mid-run:
  - Stimulus: drop reset between clock edges in HUNT with count=3.
  - Required: outputs zero immediately; after release, no match until the next start and a full PAT_W fill.
